// File: rtl/puf_reader.sv
// Arbiter-PUF read sequencer: precharge/race switching, repeated sampling, majority-voted ID with per-bit instability flags.
// Latency: a read accepted at edge E0 publishes at edge E0 + 2*SETTLE*REPEATS; done_o pulses for one cycle.
// Backpressure: none; start_i is honoured only in IDLE (the done_o cycle included) and ignored while busy_o is high.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   start_i/challenge_i  read request and challenge (latched on an accepted start)
//   busy_o, done_o       read in progress / one-cycle publish pulse
//   id_o, unstable_o     voted ID and per-bit disagreement flags, held between reads
//   switch_o             PUF switch control: 2'b00 precharge, 2'b11 race
//   challenge_o          registered challenge to the PUF
//   resp_i               raw PUF response, asynchronous to clk_i
module puf_reader #(
    parameter int ID_W    = 96,
    parameter int CHAL_W  = 32,
    parameter int REPEATS = 15,
    parameter int SETTLE  = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [CHAL_W-1:0] challenge_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ID_W-1:0]   id_o,
    output logic [ID_W-1:0]   unstable_o,
    output logic [1:0]        switch_o,
    output logic [CHAL_W-1:0] challenge_o,
    input  logic [ID_W-1:0]   resp_i
);

    localparam int CW = $clog2(REPEATS + 1);
    localparam int RW = (REPEATS > 1) ? $clog2(REPEATS) : 1;
    localparam int PW = $clog2(SETTLE);

    localparam logic [CW-1:0] HALF     = CW'(REPEATS / 2);
    localparam logic [CW-1:0] FULL     = CW'(REPEATS);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEATS - 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRECHARGE = 2'd1,
        RACE      = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     phase_q;
    logic [RW-1:0]     rep_q;
    logic [CW-1:0]     ones_q  [ID_W];
    logic [CW-1:0]     ones_nx [ID_W];
    logic [ID_W-1:0]   resp_s1, resp_s2;
    logic [1:0]        switch_q;
    logic [CHAL_W-1:0] chal_q;
    logic [ID_W-1:0]   id_q, unstable_q;
    logic              done_q;

    logic accept, phase_last, rep_last, sample_en, publish;

    assign accept     = (state_q == IDLE) && start_i;
    assign phase_last = (phase_q == PH_LAST);
    assign rep_last   = (rep_q == REP_LAST);
    assign sample_en  = (state_q == RACE) && phase_last;
    assign publish    = sample_en && rep_last;

    // Free-running two-flop synchroniser; the PUF outputs are not related to clk_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_s1 <= '0;
            resp_s2 <= '0;
        end else begin
            resp_s1 <= resp_i;
            resp_s2 <= resp_s1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (start_i) state_d = PRECHARGE;
            PRECHARGE: if (phase_last) state_d = RACE;
            RACE:      if (phase_last) state_d = rep_last ? IDLE : PRECHARGE;
            default:   state_d = IDLE;
        endcase
    end

    // Counts including the sample taken this cycle; the publish path votes on these
    // so the final race contributes to the result.
    always_comb begin
        for (int i = 0; i < ID_W; i++) begin
            ones_nx[i] = ones_q[i] + CW'(resp_s2[i]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q  <= '0;
            rep_q    <= '0;
            switch_q <= 2'b00;
            chal_q   <= '0;
            for (int i = 0; i < ID_W; i++) begin
                ones_q[i] <= '0;
            end
        end else begin
            // Switch is registered from the next state so it changes exactly at the phase edges.
            switch_q <= (state_d == RACE) ? 2'b11 : 2'b00;

            if (accept) begin
                chal_q  <= challenge_i;
                phase_q <= '0;
                rep_q   <= '0;
                for (int i = 0; i < ID_W; i++) begin
                    ones_q[i] <= '0;
                end
            end else if (state_q != IDLE) begin
                phase_q <= phase_last ? '0 : phase_q + 1'b1;
                if (sample_en) begin
                    for (int i = 0; i < ID_W; i++) begin
                        ones_q[i] <= ones_nx[i];
                    end
                    if (!rep_last) begin
                        rep_q <= rep_q + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_q       <= '0;
            unstable_q <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= publish;
            if (publish) begin
                for (int i = 0; i < ID_W; i++) begin
                    id_q[i]       <= (ones_nx[i] > HALF);
                    unstable_q[i] <= (ones_nx[i] != '0) && (ones_nx[i] != FULL);
                end
            end
        end
    end

    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;
    assign id_o        = id_q;
    assign unstable_o  = unstable_q;
    assign switch_o    = switch_q;
    assign challenge_o = chal_q;

endmodule

// File: doc/puf_reader.md
# puf_reader

Sequencer that drives the arbiter-PUF array and reads it out. Latches a challenge, fires the arbiters repeatedly through the precharge/race switch sequence, synchronises and accumulates each response bit, and publishes a majority-voted device ID with a per-bit instability flag. Sits between the `puf` array and the key-derivation/register logic that consumes the ID.

## Interface

Parameters:
- `ID_W`, 96: response/ID width; equals the PUF `id_o` width.
- `CHAL_W`, 32: challenge width.
- `REPEATS`, 15: evaluations per read. Must be odd and ≥1.
- `SETTLE`, 8: cycles per switch phase. Must be ≥4.

Ports:
- `clk_i`  in  1  single clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `start_i`  in  1  request a read; honoured only in IDLE.
- `challenge_i`  in  CHAL_W  challenge, latched on accepted start.
- `busy_o`  out  1  read in progress.
- `done_o`  out  1  one-cycle pulse when `id_o`/`unstable_o` update.
- `id_o`  out  ID_W  majority-voted ID; held until next completion.
- `unstable_o`  out  ID_W  bit set where not all REPEATS samples agreed.
- `switch_o`  out  2  to PUF `switch_i`: 2'b00 precharge, 2'b11 race.
- `challenge_o`  out  CHAL_W  to PUF `challenge_i`; registered.
- `resp_i`  in  ID_W  from PUF `id_o`; asynchronous to `clk_i`.

## Operation

- Reset values: `busy_o`=0, `done_o`=0, `id_o`=0, `unstable_o`=0, `switch_o`=2'b00, `challenge_o`=0, all counters 0, state IDLE.
- `resp_i` passes through a 2-flop synchroniser per bit, free-running.
- Per-bit ones counters, width `$clog2(REPEATS+1)`. The repetition counter runs 0..REPEATS-1. The phase counter runs 0..SETTLE-1.
- States:
  - IDLE: `switch_o`=00, `busy_o`=0. On `start_i`=1: latch `challenge_i` into `challenge_o`, clear the ones and repetition counters, go to PRECHARGE.
  - PRECHARGE: `switch_o`=00 for SETTLE cycles, then go to RACE.
  - RACE: `switch_o`=11 for SETTLE cycles. On its last cycle, add each synchronised bit to its ones counter. If rep==REPEATS-1, go to IDLE and publish. Otherwise rep++ and go to PRECHARGE.
- Publish (registered, at the edge leaving the final RACE):
  - `id_o[i]` = (ones[i] > REPEATS/2), using integer division.
  - `unstable_o[i]` = (ones[i] != 0 && ones[i] != REPEATS).
  - `done_o`=1 for that one cycle only.
- The publish path uses the updated count, including the final sample.
- `start_i` while busy is ignored. `challenge_i` changes while busy do not affect `challenge_o`.
- `challenge_o` holds its last value in IDLE.
- Reset asserted mid-read aborts immediately to the reset values. No partial publish.
- REPEATS=1: `id_o` equals the single sample and `unstable_o` is always 0.

## Timing

- Start accepted at edge E0 (IDLE, `start_i`=1).
  - From E0: `busy_o`=1, `switch_o`=00, `challenge_o` valid.
- Each repetition lasts 2·SETTLE cycles. The race edge occurs at E0+SETTLE+k·2·SETTLE.
- Sample point: the last RACE cycle, SETTLE−1 cycles after the race edge. Through the synchroniser this reflects `resp_i` from ≥SETTLE−3 cycles after launch.
- Publish at edge E0+2·SETTLE·REPEATS.
  - From that edge: `done_o`=1, `busy_o`=0, new `id_o`/`unstable_o`.
  - One cycle later: `done_o`=0.
- Defaults give 240 cycles.
- The cycle with `done_o`=1 is in IDLE, so `start_i` in that cycle is accepted (back-to-back reads, zero gap).

## Test plan

- Reset: hold `rst_ni`=0 and toggle inputs → all outputs 0 and `switch_o`=00. Release, idle 20 cycles → no change.
- Stable read: behavioural PUF returns 96'hDEAD_BEEF_0123_4567_89AB_CDEF on race, `challenge_i`=32'h1234_5678, start → `challenge_o`=32'h1234_5678 from E0, 15 race pulses of 8 cycles each, `done_o` at E0+240 for 1 cycle, `id_o`=that value, `unstable_o`=0.
- Noisy bits: bit 3 returns 1 in 8 of 15 races and bit 7 returns 1 in 7 of 15 → `id_o[3]`=1, `id_o[7]`=0, `unstable_o`=96'h88, all other bits match the stable pattern.
- Ignored inputs: `start_i` pulses and `challenge_i`=32'hFFFF_FFFF at E0+50 → single `done_o` at E0+240, `challenge_o` unchanged.
- Mid-run reset: `rst_ni` low at E0+100 → outputs 0 within the same cycle (async). Re-start after release → full 240-cycle read with correct `id_o`.
- Back-to-back: `start_i` high in the `done_o` cycle with a new challenge → second read starts immediately. Second `done_o` 240 cycles later. `id_o` holds the first result until then.
